// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between pipeline_ctrl (master) and the datapath/memories (slave).
// PIPELINE_PERF_CNT_EN adds the performance counter outputs and their width parameter.
interface pipeline_ctrl_if #(
  parameter int INSTRUCTION_WIDTH        = 32,
  parameter int REG_ADDRESS_LENGTH       = 5,
  parameter int IMMEDIATE_ADDRESS_LENGTH = 16
`ifdef PIPELINE_PERF_CNT_EN
  , parameter int CNT_WIDTH              = 32
`endif
);
  logic [INSTRUCTION_WIDTH-1:0]        imem_instruction, imem_address, id_instruction;
  logic [REG_ADDRESS_LENGTH-1:0]       id_rs_a, id_rs_b, id_rd, wb_rd;
  logic                                id_use_a, id_use_b, id_we, id_load, id_mem;
  logic                                id_branch_taken;
  logic [IMMEDIATE_ADDRESS_LENGTH-1:0] id_branch_target;
  logic                                dmem_ack, dmem_req;
  logic [1:0]                          fwd_sel_a, fwd_sel_b;
  logic                                idex_en, exwb_en, idex_bubble, wb_we;
  logic                                stall, freeze, flush;
`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0]                perf_cycles, perf_stalls, perf_flushes;
`endif

  modport master (
`ifdef PIPELINE_PERF_CNT_EN
    output perf_cycles, perf_stalls, perf_flushes,
`endif
    input  imem_instruction, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd,
           id_we, id_load, id_mem, id_branch_taken, id_branch_target, dmem_ack,
    output imem_address, id_instruction, dmem_req, fwd_sel_a, fwd_sel_b,
           idex_en, exwb_en, idex_bubble, wb_we, wb_rd, stall, freeze, flush
  );

  modport slave (
`ifdef PIPELINE_PERF_CNT_EN
    input  perf_cycles, perf_stalls, perf_flushes,
`endif
    output imem_instruction, id_rs_a, id_rs_b, id_use_a, id_use_b, id_rd,
           id_we, id_load, id_mem, id_branch_taken, id_branch_target, dmem_ack,
    input  imem_address, id_instruction, dmem_req, fwd_sel_a, fwd_sel_b,
           idex_en, exwb_en, idex_bubble, wb_we, wb_rd, stall, freeze, flush
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Sequencing/hazard control for a 4-stage in-order pipeline (IF, ID, EX/MEM, WB).
// Optional PIPELINE_PERF_CNT_EN adds saturating cycle/stall/flush counters.
module pipeline_ctrl #(
  parameter int INSTRUCTION_WIDTH        = 32,
  parameter int REG_ADDRESS_LENGTH       = 5,
  parameter int IMMEDIATE_ADDRESS_LENGTH = 16,
  parameter int PC_INC                   = 1
`ifdef PIPELINE_PERF_CNT_EN
  , parameter int CNT_WIDTH              = 32
`endif
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.master bus
);
  localparam int IW = INSTRUCTION_WIDTH;
  localparam int RA = REG_ADDRESS_LENGTH;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          load;
    logic          mem;
    logic [RA-1:0] rd;
  } stage_t;

  logic [IW-1:0] pc, ir;
  logic          id_valid;
  stage_t        ex, wb;
  logic          freeze, stall, flush, hit_a, hit_b, take;

  // EX result beats WB result; a load in EX cannot forward (that case stalls instead).
  function automatic logic [1:0] fwd(input logic [RA-1:0] rs, input logic idv,
                                     input stage_t e, input stage_t w);
    if (!idv)                                   return 2'd0;
    if (e.valid && e.we && !e.load && rs == e.rd) return 2'd1;
    if (w.valid && w.we && rs == w.rd)          return 2'd2;
    return 2'd0;
  endfunction

  assign freeze = ex.valid & ex.mem & ~bus.dmem_ack;
  assign hit_a  = bus.id_use_a & (bus.id_rs_a == ex.rd);
  assign hit_b  = bus.id_use_b & (bus.id_rs_b == ex.rd);
  assign stall  = ~freeze & id_valid & ex.valid & ex.load & ex.we & (hit_a | hit_b);
  assign flush  = ~freeze & ~stall & id_valid & bus.id_branch_taken;
  assign take   = id_valid & ~stall;

  assign bus.imem_address   = pc;
  assign bus.id_instruction = ir;
  assign bus.dmem_req       = ex.valid & ex.mem;
  assign bus.freeze         = freeze;
  assign bus.stall          = stall;
  assign bus.flush          = flush;
  assign bus.idex_en        = ~freeze;
  assign bus.exwb_en        = ~freeze;
  assign bus.idex_bubble    = stall;
  assign bus.wb_we          = wb.valid & wb.we & ~freeze;
  assign bus.wb_rd          = wb.rd;
  assign bus.fwd_sel_a      = fwd(bus.id_rs_a, id_valid, ex, wb);
  assign bus.fwd_sel_b      = fwd(bus.id_rs_b, id_valid, ex, wb);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      ir       <= '0;
      id_valid <= 1'b0;
      ex       <= '0;
      wb       <= '0;
    end else if (!freeze) begin
      wb       <= ex;
      ex.valid <= take;
      ex.we    <= take & bus.id_we;
      ex.load  <= take & bus.id_load;
      ex.mem   <= take & bus.id_mem;
      ex.rd    <= bus.id_rd;
      if (flush) begin
        pc       <= IW'(bus.id_branch_target);
        ir       <= '0;
        id_valid <= 1'b0;
      end else if (!stall) begin
        pc       <= pc + IW'(PC_INC);
        ir       <= bus.imem_instruction;
        id_valid <= 1'b1;
      end
    end
  end

`ifdef PIPELINE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] cyc_q, stl_q, fls_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
    return (en && !(&c)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      stl_q <= '0;
      fls_q <= '0;
    end else begin
      cyc_q <= sat_inc(cyc_q, 1'b1);
      stl_q <= sat_inc(stl_q, stall | freeze);
      fls_q <= sat_inc(fls_q, flush);
    end
  end

  assign bus.perf_cycles  = cyc_q;
  assign bus.perf_stalls  = stl_q;
  assign bus.perf_flushes = fls_q;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + randomized bench for pipeline_ctrl against a behavioural stage model.
module tb_pipeline_ctrl;
  localparam int IW = 32, RA = 5, IA = 16, PC_INC = 1;
`ifdef PIPELINE_PERF_CNT_EN
  localparam int CW = 4;
`endif
  localparam logic [31:0] TAG = 32'hABC0_0000;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

`ifdef PIPELINE_PERF_CNT_EN
  pipeline_ctrl_if #(.INSTRUCTION_WIDTH(IW), .REG_ADDRESS_LENGTH(RA),
                     .IMMEDIATE_ADDRESS_LENGTH(IA), .CNT_WIDTH(CW)) bus();
  pipeline_ctrl #(.INSTRUCTION_WIDTH(IW), .REG_ADDRESS_LENGTH(RA),
                  .IMMEDIATE_ADDRESS_LENGTH(IA), .PC_INC(PC_INC), .CNT_WIDTH(CW))
    dut (.clk(clk), .rst(rst), .bus(bus));
`else
  pipeline_ctrl_if #(.INSTRUCTION_WIDTH(IW), .REG_ADDRESS_LENGTH(RA),
                     .IMMEDIATE_ADDRESS_LENGTH(IA)) bus();
  pipeline_ctrl #(.INSTRUCTION_WIDTH(IW), .REG_ADDRESS_LENGTH(RA),
                  .IMMEDIATE_ADDRESS_LENGTH(IA), .PC_INC(PC_INC))
    dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  int errors = 0, checks = 0;

  typedef struct { bit v, we, ld, mem; bit [RA-1:0] rd; } slot_t;
  bit [IW-1:0] m_pc, m_ir;
  bit          m_idv, m_known, imem_from_pc;
  slot_t       m_ex, m_wb;
  bit          e_req, e_freeze, e_stall, e_flush, e_wb_we;
  bit [1:0]    e_fa, e_fb;
`ifdef PIPELINE_PERF_CNT_EN
  bit [CW-1:0] m_cyc, m_stl, m_fls;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [1:0] m_fwd(input bit [RA-1:0] rs);
    if (!m_idv) return 2'd0;
    if (m_ex.v && m_ex.we && !m_ex.ld && rs == m_ex.rd) return 2'd1;
    if (m_wb.v && m_wb.we && rs == m_wb.rd) return 2'd2;
    return 2'd0;
  endfunction

  function automatic void predict();
    bit hazard;
    e_req    = m_ex.v && m_ex.mem;
    e_freeze = e_req && !bus.dmem_ack;
    hazard   = (bus.id_use_a && bus.id_rs_a == m_ex.rd) || (bus.id_use_b && bus.id_rs_b == m_ex.rd);
    e_stall  = !e_freeze && m_idv && m_ex.v && m_ex.ld && m_ex.we && hazard;
    e_flush  = !e_freeze && !e_stall && m_idv && bus.id_branch_taken;
    e_wb_we  = m_wb.v && m_wb.we && !e_freeze;
    e_fa     = m_fwd(bus.id_rs_a);
    e_fb     = m_fwd(bus.id_rs_b);
  endfunction

  task automatic compare_all();
    if (!m_known) return;
    chk("imem_address",   32'(bus.imem_address),   32'(m_pc));
    chk("id_instruction", 32'(bus.id_instruction), 32'(m_ir));
    chk("dmem_req",       32'(bus.dmem_req),       32'(e_req));
    chk("freeze",         32'(bus.freeze),         32'(e_freeze));
    chk("stall",          32'(bus.stall),          32'(e_stall));
    chk("flush",          32'(bus.flush),          32'(e_flush));
    chk("fwd_sel_a",      32'(bus.fwd_sel_a),      32'(e_fa));
    chk("fwd_sel_b",      32'(bus.fwd_sel_b),      32'(e_fb));
    chk("idex_en",        32'(bus.idex_en),        32'(!e_freeze));
    chk("exwb_en",        32'(bus.exwb_en),        32'(!e_freeze));
    chk("idex_bubble",    32'(bus.idex_bubble),    32'(e_stall));
    chk("wb_we",          32'(bus.wb_we),          32'(e_wb_we));
    if (e_wb_we) chk("wb_rd", 32'(bus.wb_rd), 32'(m_wb.rd));
`ifdef PIPELINE_PERF_CNT_EN
    chk("perf_cycles",  32'(bus.perf_cycles),  32'(m_cyc));
    chk("perf_stalls",  32'(bus.perf_stalls),  32'(m_stl));
    chk("perf_flushes", 32'(bus.perf_flushes), 32'(m_fls));
`endif
  endtask

  // Pipeline-level effect of one clock edge, from the hazard rules.
  task automatic model_edge();
    slot_t nx;
    if (rst) begin
      m_pc = '0; m_ir = '0; m_idv = 0; m_ex = '{default: 0}; m_wb = '{default: 0};
`ifdef PIPELINE_PERF_CNT_EN
      m_cyc = '0; m_stl = '0; m_fls = '0;
`endif
      m_known = 1;
      return;
    end
`ifdef PIPELINE_PERF_CNT_EN
    if (m_cyc != '1) m_cyc++;
    if ((e_stall || e_freeze) && m_stl != '1) m_stl++;
    if (e_flush && m_fls != '1) m_fls++;
`endif
    if (e_freeze) return;
    nx.v   = m_idv && !e_stall;
    nx.we  = nx.v && bus.id_we;
    nx.ld  = nx.v && bus.id_load;
    nx.mem = nx.v && bus.id_mem;
    nx.rd  = bus.id_rd;
    m_wb = m_ex;
    m_ex = nx;
    if (e_stall) ;
    else if (e_flush) begin m_pc = IW'(bus.id_branch_target); m_ir = '0; m_idv = 0; end
    else begin m_pc = m_pc + IW'(PC_INC); m_ir = bus.imem_instruction; m_idv = 1; end
  endtask

  task automatic settle();
    #1;
    if (imem_from_pc) bus.imem_instruction = TAG | bus.imem_address;
    #1;
    predict();
    compare_all();
  endtask

  task automatic advance();
    predict();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_id(input int ra, input bit ua, input int rb, input bit ub, input int rd,
                        input bit we, input bit ld, input bit mem, input bit br, input int tgt);
    bus.id_rs_a = RA'(ra); bus.id_use_a = ua; bus.id_rs_b = RA'(rb); bus.id_use_b = ub;
    bus.id_rd = RA'(rd); bus.id_we = we; bus.id_load = ld; bus.id_mem = mem;
    bus.id_branch_taken = br; bus.id_branch_target = IA'(tgt);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.dmem_ack = 1'b1;
  endtask

  initial begin
    imem_from_pc = 1;
    bus.imem_instruction = TAG;
    idle();
    rst = 1;
    @(posedge clk); model_edge(); @(negedge clk);
    settle();
    chk("rst_pc",    32'(bus.imem_address), 32'h0);
    chk("rst_ir",    32'(bus.id_instruction), 32'h0);
    chk("rst_req",   32'(bus.dmem_req), 32'h0);
    chk("rst_flags", 32'({bus.stall, bus.freeze, bus.flush, bus.wb_we}), 32'h0);
    chk("rst_fwd",   32'({bus.fwd_sel_a, bus.fwd_sel_b}), 32'h0);
    advance();
    rst = 0;

    for (int k = 0; k < 4; k++) begin
      settle();
      chk("seq_pc", 32'(bus.imem_address), 32'(k));
      if (k > 0) chk("seq_ir", 32'(bus.id_instruction), TAG | 32'(k - 1));
      advance();
    end

    // EX forward then WB forward of r3
    set_id(0, 0, 0, 0, 3, 1, 0, 0, 0, 0); settle(); advance();
    set_id(3, 1, 0, 0, 7, 1, 0, 0, 0, 0); settle();
    chk("fwd_ex", 32'(bus.fwd_sel_a), 32'd1); advance();
    set_id(3, 1, 0, 0, 8, 0, 0, 0, 0, 0); settle();
    chk("fwd_wb", 32'(bus.fwd_sel_a), 32'd2);
    chk("wb_we_r3", 32'(bus.wb_we), 32'd1);
    chk("wb_rd_r3", 32'(bus.wb_rd), 32'd3); advance();

    // load-use on B
    set_id(0, 0, 0, 0, 5, 1, 1, 1, 0, 0); settle(); advance();
    set_id(0, 0, 5, 1, 9, 1, 0, 0, 0, 0); settle();
    chk("lu_stall", 32'(bus.stall), 32'd1);
    chk("lu_bubble", 32'(bus.idex_bubble), 32'd1);
    chk("lu_pc", 32'(bus.imem_address), 32'd8); advance();
    settle();
    chk("lu_stall_once", 32'(bus.stall), 32'd0);
    chk("lu_pc_held", 32'(bus.imem_address), 32'd8);
    chk("lu_fwd_wb", 32'(bus.fwd_sel_b), 32'd2); advance();

    // store with 3 wait cycles; taken branch in ID must wait out the freeze
    set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); settle(); advance();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0040);
    bus.dmem_ack = 0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("fz_req", 32'(bus.dmem_req), 32'd1);
      chk("fz_freeze", 32'(bus.freeze), 32'd1);
      chk("fz_flush", 32'(bus.flush), 32'd0);
      chk("fz_wb_we", 32'(bus.wb_we), 32'd0);
      chk("fz_pc", 32'(bus.imem_address), 32'd10);
      chk("fz_ir", 32'(bus.id_instruction), TAG | 32'd9);
      advance();
    end
    bus.dmem_ack = 1; settle();
    chk("ack_req", 32'(bus.dmem_req), 32'd1);
    chk("ack_freeze", 32'(bus.freeze), 32'd0);
    chk("br_flush", 32'(bus.flush), 32'd1); advance();
    settle();
    chk("br_pc", 32'(bus.imem_address), 32'h40);
    chk("br_ir", 32'(bus.id_instruction), 32'h0);
    chk("br_idv0", 32'(bus.flush), 32'd0); advance();

    // reset lands in the middle of a freeze
    set_id(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); settle(); advance();
    idle(); bus.dmem_ack = 0; settle();
    chk("rf_freeze1", 32'(bus.freeze), 32'd1); advance();
    rst = 1; settle();
    chk("rf_freeze2", 32'(bus.freeze), 32'd1); advance();
    rst = 0; settle();
    chk("rf_req", 32'(bus.dmem_req), 32'd0);
    chk("rf_pc", 32'(bus.imem_address), 32'd0);
`ifdef PIPELINE_PERF_CNT_EN
    chk("rf_perf", 32'({bus.perf_cycles, bus.perf_stalls, bus.perf_flushes}), 32'd0);
`endif
    advance();

    imem_from_pc = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      bus.imem_instruction = $urandom;
      set_id($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 65535)));
      if (bus.id_load) bus.id_mem = 1;
      bus.dmem_ack = ($urandom_range(0, 2) != 0);
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Parametrised control and sequencing unit for the next-generation 4-stage in-order pipeline: IF, ID, EX/MEM, WB. It owns the PC and the IF/ID instruction register, and tracks per-stage valid/rd/write-enable/load state. It generates 3-way forwarding selects, load-use stalls, branch flushes, and a req/ack data-memory handshake that freezes the pipeline on multi-cycle accesses. The datapath (register file, ALU, stage data registers) sits outside and is steered by this block's enables and selects.

Parameters:
INSTRUCTION_WIDTH, 32, instruction and PC width
REG_ADDRESS_LENGTH, 5, register address width
IMMEDIATE_ADDRESS_LENGTH, 16, branch target width (zero-extended into PC)
PC_INC, 1, PC increment per fetched instruction
CNT_WIDTH, 32, performance counter width (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_instruction  in  INSTRUCTION_WIDTH  fetched instruction at imem_address
imem_address  out  INSTRUCTION_WIDTH  current PC
id_instruction  out  INSTRUCTION_WIDTH  IF/ID register contents, to decoder
id_rs_a, id_rs_b  in  REG_ADDRESS_LENGTH  decoded source addresses in ID
id_use_a, id_use_b  in  1  source is actually read
id_rd  in  REG_ADDRESS_LENGTH  decoded destination
id_we, id_load, id_mem  in  1  writes reg / is load / is load-or-store
id_branch_taken  in  1  branch in ID resolved taken
id_branch_target  in  IMMEDIATE_ADDRESS_LENGTH  branch target
dmem_ack  in  1  data memory completes access this cycle
dmem_req  out  1  EX holds valid memory op awaiting ack
fwd_sel_a, fwd_sel_b  out  2  0 regfile, 1 EX result, 2 WB result
idex_en, exwb_en  out  1  datapath stage register load enables
idex_bubble  out  1  datapath clears ID/EX payload this edge
wb_we  out  1  register-file write enable (valid & we in WB)
wb_rd  out  REG_ADDRESS_LENGTH  register-file write address
stall, freeze, flush  out  1  load-use stall / memory freeze / branch flush status

Behaviour:
- Reset (sync, rst=1 at edge): PC=0, id_instruction=0, all stage valid/we/load/mem bits=0, wb_rd=0. Combinational outputs then: dmem_req=0, stall=0, freeze=0, flush=0, fwd_sel=0, wb_we=0. rst overrides freeze; an outstanding dmem request is abandoned. The external memory must ignore a dropped req.
- Instruction in ID is valid iff id_valid=1. Decoded id_* inputs are ignored when id_valid=0.
- freeze = ex_valid & ex_mem & ~dmem_ack. When freeze=1: PC, IF/ID, ID/EX and EX/WB all hold. idex_en=exwb_en=0. WB does not re-write: wb_we=0 while frozen. Zero-wait ack (ack in first req cycle) gives no freeze.
- dmem_req = ex_valid & ex_mem. Held until the ack cycle. An ack while req=0 is ignored.
- stall (load-use) = ~freeze & id_valid & ex_valid & ex_load & ex_we & ((id_use_a & id_rs_a==ex_rd) | (id_use_b & id_rs_b==ex_rd)). When stall=1: PC and IF/ID hold, idex_bubble=1 (EX valid cleared next edge), and EX/WB advances.
- flush = ~freeze & ~stall & id_valid & id_branch_taken. When flush=1: PC <= zero-extended target, IF/ID <= 0 with id_valid=0, and the branch itself advances.
- Priority: freeze > stall > flush > normal advance (PC += PC_INC, IF/ID <= imem_instruction, id_valid=1).
- Forwarding, per source: EX match (ex_valid & ex_we & ~ex_load & rs==ex_rd) -> 1. Otherwise WB match (wb_valid & wb_we_raw & rs==wb_rd) -> 2. Otherwise 0. EX has priority. Register 0 is ordinary, so matches on 0 forward.
- PC wraps modulo 2^INSTRUCTION_WIDTH with no flag.

Optional Feature:
PIPELINE_PERF_CNT_EN: adds outputs perf_cycles, perf_stalls, perf_flushes (CNT_WIDTH each), reset to 0 and incremented once per cycle when rst=0 / stall|freeze / flush respectively, saturating at all-ones. Without the macro the ports and logic are absent.

Test Plan:
- rst held 2 cycles, release -> imem_address 0,1,2,3 on successive cycles; id_instruction follows imem_instruction one cycle later; outputs all 0 during reset.
- EX: add r3 (we=1); ID reads r3 on A -> fwd_sel_a=1. Next cycle, with an unrelated EX op and r3 in WB -> fwd_sel_a=2.
- EX: load r5; ID uses r5 on B -> stall=1 for exactly 1 cycle, PC held, idex_bubble=1; next cycle fwd_sel_b=2, no stall.
- Store in EX, dmem_ack low 3 cycles then high -> dmem_req=1 for 4 cycles, freeze=1 for 3, PC/id_instruction unchanged, wb_we=0 during freeze.
- ID branch taken to 0x0040 -> flush=1, next imem_address=0x40, next id_valid=0. Same branch coinciding with freeze -> ignored until the freeze ends.
- rst asserted during 2nd freeze cycle -> next cycle dmem_req=0, PC=0; with PIPELINE_PERF_CNT_EN counters read 0.
